// File: rtl/pulse_voice.sv
// pulse_voice: single-clock square/pattern voice with ADSR-style envelope,
// period sweep, step sequencer and stereo pan.
//
// Ports:
//   clk_50mhz        system clock
//   reset            asynchronous active-high reset
//   trigger          one-cycle note restart strobe
//   gate             note held; a falling edge requests release
//   env_mode         1 = envelope volume, 0 = constant sus_vol
//   sus_vol          sustain / constant volume
//   atk_time..rel_time  envelope ticks per step for each phase
//   sus_time         sustain length in envelope ticks (8'hFF = hold while gate)
//   loop_cnt         extra envelope repeats after release
//   swp_rst_on_loop  reload the sweep at each envelope loop restart
//   duty_pattern     waveform bit per sequencer step (1 = +AMP, 0 = -AMP)
//   timer_period     starting pitch period
//   swp_en/swp_neg/swp_shift/swp_period  period sweep controls
//   pan              0 = full left, 31 = near-full right
//   audio_out_left/right  signed samples, updated once per sample strobe
//   sample_valid     one-cycle pulse while freshly updated samples are shown
//   active           envelope is not idle
module pulse_voice #(
    parameter int VOL_W     = 6,
    parameter int TIMER_W   = 11,
    parameter int SEQ_STEPS = 16,
    parameter int OUT_W     = 16,
    parameter int AMP       = 30000,
    parameter int PRESC     = 28,
    parameter int ENV_DIV   = 6250,
    parameter int SMP_DIV   = 1042
) (
    input  logic                      clk_50mhz,
    input  logic                      reset,
    input  logic                      trigger,
    input  logic                      gate,
    input  logic                      env_mode,
    input  logic [VOL_W-1:0]          sus_vol,
    input  logic [7:0]                atk_time,
    input  logic [7:0]                dcy_time,
    input  logic [7:0]                sus_time,
    input  logic [7:0]                rel_time,
    input  logic [3:0]                loop_cnt,
    input  logic                      swp_rst_on_loop,
    input  logic [SEQ_STEPS-1:0]      duty_pattern,
    input  logic [TIMER_W-1:0]        timer_period,
    input  logic                      swp_en,
    input  logic                      swp_neg,
    input  logic [2:0]                swp_shift,
    input  logic [2:0]                swp_period,
    input  logic [4:0]                pan,
    output logic signed [OUT_W-1:0]   audio_out_left,
    output logic signed [OUT_W-1:0]   audio_out_right,
    output logic                      sample_valid,
    output logic                      active
);

    localparam int STEP_W  = $clog2(SEQ_STEPS);
    localparam int PRESC_W = $clog2(PRESC + 2);
    localparam int ENVD_W  = $clog2(ENV_DIV + 1);
    localparam int SMPD_W  = $clog2(SMP_DIV + 1);
    localparam int PROD_W  = OUT_W + VOL_W + 1;
    localparam int MIX_W   = PROD_W + 7;

    localparam logic [VOL_W-1:0]          VOL_MAX  = {VOL_W{1'b1}};
    localparam logic signed [OUT_W-1:0]   AMP_POS  = OUT_W'(AMP);
    localparam logic signed [OUT_W-1:0]   AMP_NEG  = OUT_W'(-AMP);
    localparam logic signed [TIMER_W+1:0] CAND_MIN = (TIMER_W+2)'(8);
    localparam logic signed [TIMER_W+1:0] CAND_MAX = (TIMER_W+2)'((1 << TIMER_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ATTACK,
        S_DECAY,
        S_SUSTAIN,
        S_RELEASE
    } env_state_t;

    env_state_t               r_state;
    env_state_t               w_stateNext;
    logic [VOL_W-1:0]         r_envVol;
    logic [VOL_W-1:0]         w_envVolNext;
    logic [7:0]               r_envTime;
    logic [7:0]               w_envTimeNext;
    logic [3:0]               r_loops;
    logic [3:0]               w_loopsNext;
    logic                     w_relConsume;
    logic                     w_loopReload;

    logic [ENVD_W-1:0]        r_envDiv;
    logic [SMPD_W-1:0]        r_smpDiv;
    logic                     w_envTick;
    logic                     w_smpTick;

    logic                     r_gateDly;
    logic                     r_relReq;
    logic                     w_gateFall;

    logic [TIMER_W-1:0]       r_curPeriod;
    logic                     r_mute;
    logic [8:0]               r_swpCnt;
    logic [TIMER_W-1:0]       w_delta;
    logic signed [TIMER_W+1:0] w_cand;
    logic                     w_muteNext;
    logic                     w_swpWrap;

    logic [PRESC_W-1:0]       r_presc;
    logic [TIMER_W-1:0]       r_timerCnt;
    logic [STEP_W-1:0]        r_step;

    logic [VOL_W-1:0]         w_vol;
    logic                     w_silent;
    logic signed [OUT_W-1:0]  w_wave;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_scaled;
    logic signed [6:0]        w_panL;
    logic signed [6:0]        w_panR;
    logic signed [MIX_W-1:0]  w_mixL;
    logic signed [MIX_W-1:0]  w_mixR;

    logic signed [OUT_W-1:0]  r_outLeft;
    logic signed [OUT_W-1:0]  r_outRight;
    logic                     r_sampleValid;

    // Free-running strobe dividers; a note trigger never realigns them.
    assign w_envTick = (r_envDiv == ENVD_W'(ENV_DIV - 1));
    assign w_smpTick = (r_smpDiv == SMPD_W'(SMP_DIV - 1));

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            r_envDiv <= '0;
            r_smpDiv <= '0;
        end else begin
            r_envDiv <= w_envTick ? '0 : r_envDiv + ENVD_W'(1);
            r_smpDiv <= w_smpTick ? '0 : r_smpDiv + SMPD_W'(1);
        end
    end

    // The release request survives until an envelope tick can act on it,
    // so a short gate drop between ticks is never lost.
    assign w_gateFall = r_gateDly & ~gate;

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            r_gateDly <= 1'b0;
            r_relReq  <= 1'b0;
        end else begin
            r_gateDly <= gate;
            if (trigger) begin
                r_relReq <= 1'b0;
            end else if (w_gateFall) begin
                r_relReq <= 1'b1;
            end else if (w_relConsume) begin
                r_relReq <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_envVol  <= '0;
            r_envTime <= '0;
            r_loops   <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_envVol  <= w_envVolNext;
            r_envTime <= w_envTimeNext;
            r_loops   <= w_loopsNext;
        end
    end

    // Envelope next-state. A pending release request pre-empts the normal
    // phase rules and keeps the current volume as the release start point.
    always_comb begin
        w_stateNext   = r_state;
        w_envVolNext  = r_envVol;
        w_envTimeNext = r_envTime;
        w_loopsNext   = r_loops;
        w_relConsume  = 1'b0;
        w_loopReload  = 1'b0;
        if (trigger) begin
            w_stateNext   = S_ATTACK;
            w_envVolNext  = '0;
            w_envTimeNext = '0;
            w_loopsNext   = loop_cnt;
        end else if (w_envTick) begin
            if (r_relReq && (r_state == S_ATTACK || r_state == S_DECAY ||
                             r_state == S_SUSTAIN)) begin
                w_stateNext   = S_RELEASE;
                w_envTimeNext = '0;
                w_relConsume  = 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        w_envVolNext = '0;
                    end
                    S_ATTACK: begin
                        if (r_envTime >= atk_time) begin
                            w_envTimeNext = '0;
                            if (r_envVol == VOL_MAX) begin
                                w_stateNext = S_DECAY;
                            end else begin
                                w_envVolNext = r_envVol + VOL_W'(1);
                            end
                        end else begin
                            w_envTimeNext = r_envTime + 8'd1;
                        end
                    end
                    S_DECAY: begin
                        if (r_envTime >= dcy_time) begin
                            w_envTimeNext = '0;
                            if (r_envVol <= sus_vol) begin
                                w_stateNext = S_SUSTAIN;
                            end else begin
                                w_envVolNext = r_envVol - VOL_W'(1);
                            end
                        end else begin
                            w_envTimeNext = r_envTime + 8'd1;
                        end
                    end
                    S_SUSTAIN: begin
                        if (sus_time == 8'hFF) begin
                            if (!gate) begin
                                w_stateNext   = S_RELEASE;
                                w_envTimeNext = '0;
                            end
                        end else if (r_envTime >= sus_time) begin
                            w_stateNext   = S_RELEASE;
                            w_envTimeNext = '0;
                        end else begin
                            w_envTimeNext = r_envTime + 8'd1;
                        end
                    end
                    S_RELEASE: begin
                        if (r_envTime >= rel_time) begin
                            w_envTimeNext = '0;
                            if (r_envVol == '0) begin
                                if (r_loops != '0) begin
                                    w_loopsNext  = r_loops - 4'd1;
                                    w_stateNext  = S_ATTACK;
                                    w_loopReload = swp_rst_on_loop;
                                end else begin
                                    w_stateNext = S_IDLE;
                                end
                            end else begin
                                w_envVolNext = r_envVol - VOL_W'(1);
                            end
                        end else begin
                            w_envTimeNext = r_envTime + 8'd1;
                        end
                    end
                    default: begin
                        w_stateNext = S_IDLE;
                    end
                endcase
            end
        end
    end

    // Two guard bits keep the candidate exact for both underflow and overflow.
    assign w_delta    = r_curPeriod >> swp_shift;
    assign w_cand     = swp_neg ? ($signed({2'b00, r_curPeriod}) - $signed({2'b00, w_delta}))
                                : ($signed({2'b00, r_curPeriod}) + $signed({2'b00, w_delta}));
    assign w_muteNext = (swp_en && ((w_cand < CAND_MIN) || (w_cand > CAND_MAX))) ||
                        (timer_period < TIMER_W'(8));
    // (swp_period+1)*64-1 is just swp_period with six low ones appended.
    assign w_swpWrap  = (r_swpCnt == {swp_period, 6'h3F});

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            r_curPeriod <= timer_period;
            r_mute      <= 1'b0;
            r_swpCnt    <= '0;
        end else if (trigger || (w_envTick && w_loopReload)) begin
            r_curPeriod <= timer_period;
            r_mute      <= 1'b0;
            r_swpCnt    <= '0;
        end else if (w_envTick) begin
            r_mute <= w_muteNext;
            if (w_swpWrap) begin
                r_swpCnt <= '0;
                if (swp_en && !w_muteNext) begin
                    r_curPeriod <= w_cand[TIMER_W-1:0];
                end
            end else begin
                r_swpCnt <= r_swpCnt + 9'd1;
            end
        end
    end

    // Each sequencer step lasts (cur_period+1) prescaler wraps.
    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            r_presc    <= '0;
            r_timerCnt <= '0;
            r_step     <= '0;
        end else if (trigger) begin
            r_presc    <= '0;
            r_timerCnt <= '0;
            r_step     <= '0;
        end else if (r_presc == PRESC_W'(PRESC)) begin
            r_presc <= '0;
            if (r_timerCnt >= r_curPeriod) begin
                r_timerCnt <= '0;
                r_step     <= r_step + STEP_W'(1);
            end else begin
                r_timerCnt <= r_timerCnt + TIMER_W'(1);
            end
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    assign w_vol    = env_mode ? r_envVol : sus_vol;
    assign w_silent = (w_vol == '0) || (r_state == S_IDLE) || r_mute;
    assign w_wave   = duty_pattern[r_step] ? AMP_POS : AMP_NEG;
    assign w_prod   = PROD_W'(w_wave) * PROD_W'($signed({1'b0, w_vol}));
    assign w_scaled = w_prod >>> VOL_W;
    assign w_panR   = $signed({2'b00, pan});
    assign w_panL   = 7'sd32 - w_panR;
    assign w_mixL   = MIX_W'(w_scaled) * MIX_W'(w_panL);
    assign w_mixR   = MIX_W'(w_scaled) * MIX_W'(w_panR);

    // sample_valid is registered alongside the samples so it marks the
    // cycle in which the new values first appear.
    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            r_outLeft     <= '0;
            r_outRight    <= '0;
            r_sampleValid <= 1'b0;
        end else begin
            r_sampleValid <= w_smpTick;
            if (w_smpTick) begin
                r_outLeft  <= w_silent ? '0 : OUT_W'(w_mixL >>> 5);
                r_outRight <= w_silent ? '0 : OUT_W'(w_mixR >>> 5);
            end
        end
    end

    assign audio_out_left  = r_outLeft;
    assign audio_out_right = r_outRight;
    assign sample_valid    = r_sampleValid;
    assign active          = (r_state != S_IDLE);

endmodule

// File: tb/tb_pulse_voice.sv
// tb_pulse_voice: drives pulse_voice with directed and randomized note
// scenarios and compares every sample, sample_valid and active against a
// behavioural model of the voice.
module tb_pulse_voice;

    localparam int VOL_W     = 6;
    localparam int TIMER_W   = 11;
    localparam int SEQ_STEPS = 16;
    localparam int OUT_W     = 16;
    localparam int AMP       = 30000;
    localparam int PRESC     = 2;
    localparam int ENV_DIV   = 16;
    localparam int SMP_DIV   = 11;

    logic                    clk_50mhz = 1'b0;
    logic                    reset = 1'b1;
    logic                    trigger = 1'b0;
    logic                    gate = 1'b0;
    logic                    env_mode = 1'b0;
    logic [VOL_W-1:0]        sus_vol = '0;
    logic [7:0]              atk_time = '0;
    logic [7:0]              dcy_time = '0;
    logic [7:0]              sus_time = '0;
    logic [7:0]              rel_time = '0;
    logic [3:0]              loop_cnt = '0;
    logic                    swp_rst_on_loop = 1'b0;
    logic [SEQ_STEPS-1:0]    duty_pattern = '0;
    logic [TIMER_W-1:0]      timer_period = 11'd100;
    logic                    swp_en = 1'b0;
    logic                    swp_neg = 1'b0;
    logic [2:0]              swp_shift = '0;
    logic [2:0]              swp_period = '0;
    logic [4:0]              pan = '0;
    logic signed [OUT_W-1:0] audio_out_left;
    logic signed [OUT_W-1:0] audio_out_right;
    logic                    sample_valid;
    logic                    active;

    int  totalChecks = 0;
    int  badChecks = 0;
    bit  checkEn = 1'b0;

    // model state
    int    mEnvDiv, mSmpDiv, mEnvVol, mEnvTime, mLoops;
    int    mCur, mSwpCnt, mStep, mTimerCnt, mPresc;
    int    mOutL, mOutR;
    bit    mMute, mRelReq, mGatePrev, mValid;
    string mPhase = "idle";

    pulse_voice #(
        .VOL_W(VOL_W), .TIMER_W(TIMER_W), .SEQ_STEPS(SEQ_STEPS), .OUT_W(OUT_W),
        .AMP(AMP), .PRESC(PRESC), .ENV_DIV(ENV_DIV), .SMP_DIV(SMP_DIV)
    ) dut (
        .clk_50mhz(clk_50mhz), .reset(reset), .trigger(trigger), .gate(gate),
        .env_mode(env_mode), .sus_vol(sus_vol), .atk_time(atk_time),
        .dcy_time(dcy_time), .sus_time(sus_time), .rel_time(rel_time),
        .loop_cnt(loop_cnt), .swp_rst_on_loop(swp_rst_on_loop),
        .duty_pattern(duty_pattern), .timer_period(timer_period),
        .swp_en(swp_en), .swp_neg(swp_neg), .swp_shift(swp_shift),
        .swp_period(swp_period), .pan(pan),
        .audio_out_left(audio_out_left), .audio_out_right(audio_out_right),
        .sample_valid(sample_valid), .active(active)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        totalChecks++;
        if (observed != expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mEnvDiv = 0; mSmpDiv = 0; mEnvVol = 0; mEnvTime = 0; mLoops = 0;
        mCur = int'(timer_period); mSwpCnt = 0; mStep = 0; mTimerCnt = 0; mPresc = 0;
        mOutL = 0; mOutR = 0; mMute = 0; mRelReq = 0; mGatePrev = 0; mValid = 0;
        mPhase = "idle";
    endtask

    // One clock of the voice, written directly from its behavioural rules.
    task automatic modelStep();
        bit envTick, smpTick, gateFall, consume, reload, newMute;
        int vol, wave, scaled, delta, cand, maxV;
        maxV    = (1 << VOL_W) - 1;
        envTick = (mEnvDiv == ENV_DIV - 1);
        smpTick = (mSmpDiv == SMP_DIV - 1);
        mValid  = smpTick;
        if (smpTick) begin
            vol = env_mode ? mEnvVol : int'(sus_vol);
            if (vol == 0 || mPhase == "idle" || mMute) begin
                mOutL = 0;
                mOutR = 0;
            end else begin
                wave   = duty_pattern[mStep] ? AMP : -AMP;
                scaled = (wave * vol) >>> VOL_W;
                mOutL  = (scaled * (32 - int'(pan))) >>> 5;
                mOutR  = (scaled * int'(pan)) >>> 5;
            end
        end
        mEnvDiv  = envTick ? 0 : mEnvDiv + 1;
        mSmpDiv  = smpTick ? 0 : mSmpDiv + 1;
        gateFall = mGatePrev && !gate;
        mGatePrev = gate;
        consume = 0;
        reload  = 0;
        if (trigger) begin
            mPhase = "attack"; mEnvVol = 0; mEnvTime = 0; mLoops = int'(loop_cnt);
            mCur = int'(timer_period); mMute = 0; mSwpCnt = 0;
            mStep = 0; mTimerCnt = 0; mPresc = 0; mRelReq = 0;
        end else begin
            if (mPresc == PRESC) begin
                mPresc = 0;
                if (mTimerCnt >= mCur) begin
                    mTimerCnt = 0;
                    mStep = (mStep + 1) % SEQ_STEPS;
                end else begin
                    mTimerCnt++;
                end
            end else begin
                mPresc++;
            end
            if (envTick) begin
                if (mRelReq && (mPhase == "attack" || mPhase == "decay" || mPhase == "sustain")) begin
                    mPhase = "release"; mEnvTime = 0; consume = 1;
                end else if (mPhase == "idle") begin
                    mEnvVol = 0;
                end else if (mPhase == "attack") begin
                    if (mEnvTime >= int'(atk_time)) begin
                        mEnvTime = 0;
                        if (mEnvVol == maxV) mPhase = "decay";
                        else mEnvVol++;
                    end else mEnvTime++;
                end else if (mPhase == "decay") begin
                    if (mEnvTime >= int'(dcy_time)) begin
                        mEnvTime = 0;
                        if (mEnvVol <= int'(sus_vol)) mPhase = "sustain";
                        else mEnvVol--;
                    end else mEnvTime++;
                end else if (mPhase == "sustain") begin
                    if (sus_time == 8'hFF) begin
                        if (!gate) begin mPhase = "release"; mEnvTime = 0; end
                    end else if (mEnvTime >= int'(sus_time)) begin
                        mPhase = "release"; mEnvTime = 0;
                    end else mEnvTime++;
                end else begin
                    if (mEnvTime >= int'(rel_time)) begin
                        mEnvTime = 0;
                        if (mEnvVol == 0) begin
                            if (mLoops > 0) begin
                                mLoops--; mPhase = "attack"; reload = swp_rst_on_loop;
                            end else mPhase = "idle";
                        end else mEnvVol--;
                    end else mEnvTime++;
                end
                delta   = mCur >> swp_shift;
                cand    = swp_neg ? mCur - delta : mCur + delta;
                newMute = (swp_en && (cand < 8 || cand > (1 << TIMER_W) - 1)) ||
                          (int'(timer_period) < 8);
                if (mSwpCnt == (int'(swp_period) + 1) * 64 - 1) begin
                    mSwpCnt = 0;
                    if (swp_en && !newMute) mCur = cand;
                end else mSwpCnt++;
                mMute = newMute;
                if (reload) begin
                    mCur = int'(timer_period); mMute = 0; mSwpCnt = 0;
                end
            end
            if (gateFall) mRelReq = 1;
            else if (consume) mRelReq = 0;
        end
    endtask

    always @(posedge clk_50mhz or posedge reset) begin
        if (reset) modelReset();
        else modelStep();
    end

    always @(negedge clk_50mhz) begin
        if (!reset && checkEn) begin
            checkOutput("sample_valid", int'(sample_valid), int'(mValid));
            checkOutput("active", int'(active), (mPhase != "idle") ? 1 : 0);
            if (mValid) begin
                checkOutput("left", int'(audio_out_left), mOutL);
                checkOutput("right", int'(audio_out_right), mOutR);
            end
        end
    end

    task automatic pulseTrigger();
        @(negedge clk_50mhz);
        trigger = 1'b1;
        @(negedge clk_50mhz);
        trigger = 1'b0;
    endtask

    task automatic waitTicks(input int n);
        repeat (n * ENV_DIV) @(negedge clk_50mhz);
    endtask

    task automatic waitSample();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * SMP_DIV && !seen; i++) begin
            @(negedge clk_50mhz);
            if (sample_valid) seen = 1'b1;
        end
        if (!seen) checkOutput("sample_wait", 0, 1);
    endtask

    task automatic applyStimulus(input int cycles);
        env_mode        = ($urandom_range(0, 3) != 0);
        sus_vol         = VOL_W'($urandom_range(0, 63));
        atk_time        = 8'($urandom_range(0, 2));
        dcy_time        = 8'($urandom_range(0, 2));
        rel_time        = 8'($urandom_range(0, 2));
        sus_time        = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 20));
        loop_cnt        = 4'($urandom_range(0, 2));
        swp_rst_on_loop = 1'($urandom_range(0, 1));
        duty_pattern    = SEQ_STEPS'($urandom);
        timer_period    = TIMER_W'($urandom_range(4, 300));
        swp_en          = 1'($urandom_range(0, 1));
        swp_neg         = 1'($urandom_range(0, 1));
        swp_shift       = 3'($urandom_range(0, 7));
        swp_period      = 3'($urandom_range(0, 1));
        pan             = 5'($urandom_range(0, 31));
        gate            = 1'b1;
        pulseTrigger();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk_50mhz);
            if ($urandom_range(0, 299) == 0) gate = ~gate;
            if ($urandom_range(0, 499) == 0) pan = 5'($urandom_range(0, 31));
            trigger = ($urandom_range(0, 1499) == 0);
        end
        trigger = 1'b0;
    endtask

    initial begin
        int cnt;
        bit seen;
        repeat (3) @(negedge clk_50mhz);
        checkOutput("reset_left", int'(audio_out_left), 0);
        checkOutput("reset_active", int'(active), 0);
        reset   = 1'b0;
        checkEn = 1'b1;

        // constant volume square: 63/64 amplitude, half to each side
        env_mode = 1'b0; sus_vol = 6'd63; pan = 5'd16; duty_pattern = 16'hFF00;
        timer_period = 11'd100; swp_en = 1'b0; sus_time = 8'hFF; gate = 1'b1;
        pulseTrigger();
        waitSample();
        waitSample();
        checkOutput("const_left", int'(audio_out_left), -14766);
        checkOutput("const_right", int'(audio_out_right), -14766);

        // fastest envelope: 64 up, 32 down, 11 held, 33 release = 140 ticks
        env_mode = 1'b1; sus_vol = 6'd32; sus_time = 8'd10; loop_cnt = 4'd0;
        pulseTrigger();
        waitTicks(138);
        checkOutput("env_active_mid", int'(active), 1);
        waitTicks(4);
        checkOutput("env_idle_end", int'(active), 0);

        // indefinite sustain, gate release, and trigger beating a gate fall
        sus_time = 8'hFF;
        pulseTrigger();
        waitTicks(150);
        checkOutput("hold_active", int'(active), 1);
        gate = 1'b0;
        waitTicks(3);
        gate = 1'b1;
        waitTicks(40);
        @(negedge clk_50mhz);
        gate = 1'b0; trigger = 1'b1;
        @(negedge clk_50mhz);
        trigger = 1'b0;
        waitTicks(20);
        checkOutput("trig_beats_fall", int'(active), 1);
        gate = 1'b1;
        waitTicks(2);

        // upward sweep 600 -> 900 -> 1350 -> 2025, then out of range
        env_mode = 1'b0; sus_vol = 6'd40; sus_time = 8'hFF;
        swp_en = 1'b1; swp_neg = 1'b0; swp_shift = 3'd1; swp_period = 3'd0;
        timer_period = 11'd600;
        pulseTrigger();
        waitTicks(100);
        waitSample();
        checkOutput("sweep_audible", (audio_out_left != 0) ? 1 : 0, 1);
        waitTicks(100);
        waitSample();
        checkOutput("sweep_mute_l", int'(audio_out_left), 0);
        checkOutput("sweep_mute_r", int'(audio_out_right), 0);

        // three envelopes of 132 ticks, sweep reloaded at every loop
        env_mode = 1'b1; sus_vol = 6'd32; sus_time = 8'd2;
        loop_cnt = 4'd2; swp_rst_on_loop = 1'b1;
        pulseTrigger();
        waitTicks(380);
        waitSample();
        checkOutput("loop_active", int'(active), 1);
        checkOutput("loop_audible", (audio_out_left != 0) ? 1 : 0, 1);
        waitTicks(20);
        checkOutput("loop_idle", int'(active), 0);

        for (int ep = 0; ep < 8; ep++) applyStimulus(2500);

        // reset in the middle of a note
        env_mode = 1'b1; sus_vol = 6'd50; sus_time = 8'hFF; gate = 1'b1;
        swp_en = 1'b0; timer_period = 11'd80; loop_cnt = 4'd0; pan = 5'd5;
        pulseTrigger();
        waitTicks(30);
        @(negedge clk_50mhz);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_left", int'(audio_out_left), 0);
        checkOutput("midreset_right", int'(audio_out_right), 0);
        checkOutput("midreset_active", int'(active), 0);
        checkOutput("midreset_valid", int'(sample_valid), 0);
        repeat (3) @(negedge clk_50mhz);
        reset = 1'b0;
        cnt  = 0;
        seen = 1'b0;
        while (cnt < 4 * SMP_DIV && !seen) begin
            @(posedge clk_50mhz);
            #1;
            cnt++;
            if (sample_valid) seen = 1'b1;
        end
        checkOutput("first_valid_clocks", cnt, SMP_DIV);
        repeat (5) @(negedge clk_50mhz);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
